// File: rtl/exe_stage_mc_pkg.sv
// ----------------------------------------------------------------------------
// exe_stage_mc_pkg
// Purpose : shared definitions for the execute stage: ALU op codes, FSM state
//           encodings and the default datapath width.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package exe_stage_mc_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exe_stage_mc_mul.sv
// ----------------------------------------------------------------------------
// exe_mul_iter
// Purpose : iterative shift-add multiplier producing the low XLEN bits of a
//           product, retiring MUL_BITS_PER_CYCLE multiplier bits per cycle.
//           Word mode multiplies the low 32-bit operand halves in 32/B steps.
// Ports   : clk, rst       clock, asynchronous active-high reset
//           i_flush        abandon the current product
//           i_start        load operands and begin iterating
//           i_word         32-bit word-mode operation
//           i_op1, i_op2   multiplicand / multiplier
//           o_done         high during the final iteration cycle
//           o_product      running sum; the full product while o_done=1
// ----------------------------------------------------------------------------
module exe_mul_iter #(
  parameter int XLEN               = 64,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int B  = MUL_BITS_PER_CYCLE;
  localparam int CW = $clog2(XLEN / B) + 1;

  logic            r_active;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_last;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] w_pp [B];
  logic [XLEN-1:0] w_sum;

  // One partial product per multiplier bit retired this cycle.
  generate
    for (genvar gi = 0; gi < B; gi++) begin : g_pp
      assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
    end
  endgenerate

  always_comb begin
    w_sum = r_acc;
    for (int b = 0; b < B; b++) begin
      w_sum = w_sum + w_pp[b];
    end
  end

  // The final step's sum is exposed combinationally so the owner can capture
  // the result on the same edge that ends the iteration.
  assign o_done    = r_active & (r_cnt == r_last);
  assign o_product = w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_last   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_flush) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_last   <= i_word ? CW'(32 / B - 1) : CW'(XLEN / B - 1);
      r_mcand  <= i_word ? XLEN'(i_op1[31:0]) : i_op1;
      r_mplier <= i_word ? XLEN'(i_op2[31:0]) : i_op2;
      r_acc    <= '0;
    end else if (r_active) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << B;
      r_mplier <= r_mplier >> B;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// ----------------------------------------------------------------------------
// exe_stage_mc
// Purpose : execute stage with req/ack handshakes on both sides, flush, a
//           single-cycle integer ALU and an iterative multiplier. The result
//           is held until the memory stage acknowledges it.
// Ports   : clk, rst                 clock, asynchronous active-high reset
//           i_ex_flush               kill the in-flight op
//           i_ex_decoded_req/ack     upstream handshake (ack combinational)
//           i_ex_pc/inst/aluop/word  op description
//           i_ex_op1/op2             operands
//           i_ex_rd_wen/rd_addr      destination
//           o_ex_executed_req/ack    downstream handshake
//           o_ex_pc/inst/rd_*        held op fields and result
//           o_ex_busy                multiplier iterating
// ----------------------------------------------------------------------------
module exe_stage_mc
  import exe_stage_mc_pkg::*;
#(
  parameter int XLEN               = XLEN_DEFAULT,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ex_flush,
  input  logic            i_ex_decoded_req,
  output logic            o_ex_decoded_ack,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [31:0]     i_ex_inst,
  input  logic [3:0]      i_ex_aluop,
  input  logic            i_ex_word,
  input  logic [XLEN-1:0] i_ex_op1,
  input  logic [XLEN-1:0] i_ex_op2,
  input  logic            i_ex_rd_wen,
  input  logic [4:0]      i_ex_rd_addr,
  output logic            o_ex_executed_req,
  input  logic            i_ex_executed_ack,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [31:0]     o_ex_inst,
  output logic            o_ex_rd_wen,
  output logic [4:0]      o_ex_rd_addr,
  output logic [XLEN-1:0] o_ex_rd_wdata,
  output logic            o_ex_busy
);

  localparam int SHW = $clog2(XLEN);

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_rd_wen;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_word;
  logic [3:0]      r_aluop;

  logic            w_hs;
  logic            w_is_mul;
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_product;
  logic [XLEN-1:0] w_mul_result;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_a_zx;
  logic [XLEN-1:0] w_b_zx;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_alu_result;

  // Gated by rst so every output reads 0 while reset is held.
  assign o_ex_decoded_ack = ~rst & ~i_ex_flush &
                            ((r_state == ST_IDLE) |
                             ((r_state == ST_DONE) & i_ex_executed_ack));
  assign w_hs     = i_ex_decoded_req & o_ex_decoded_ack;
  assign w_is_mul = (i_ex_aluop == ALU_MUL);

  // Single-cycle ALU. Word mode works on sign-extended low words so that
  // SRA shifts in the word's sign; SRL/SLTU use the zero-extended words.
  always_comb begin
    w_a_zx  = XLEN'(i_ex_op1[31:0]);
    w_b_zx  = XLEN'(i_ex_op2[31:0]);
    w_a     = i_ex_word ? XLEN'($signed(i_ex_op1[31:0])) : i_ex_op1;
    w_b     = i_ex_word ? XLEN'($signed(i_ex_op2[31:0])) : i_ex_op2;
    w_shamt = i_ex_word ? SHW'(i_ex_op2[4:0]) : i_ex_op2[SHW-1:0];
    w_raw   = w_a + w_b;
    case (i_ex_aluop)
      ALU_SUB:  w_raw = w_a - w_b;
      ALU_AND:  w_raw = w_a & w_b;
      ALU_OR:   w_raw = w_a | w_b;
      ALU_XOR:  w_raw = w_a ^ w_b;
      ALU_SLL:  w_raw = w_a << w_shamt;
      ALU_SRL:  w_raw = (i_ex_word ? w_a_zx : i_ex_op1) >> w_shamt;
      ALU_SRA:  w_raw = $signed(w_a) >>> w_shamt;
      ALU_SLT:  w_raw = XLEN'($signed(w_a) < $signed(w_b));
      ALU_SLTU: w_raw = i_ex_word ? XLEN'(w_a_zx < w_b_zx)
                                  : XLEN'(i_ex_op1 < i_ex_op2);
      default:  w_raw = w_a + w_b;
    endcase
    w_alu_result = i_ex_word ? XLEN'($signed(w_raw[31:0])) : w_raw;
  end

  assign w_mul_result = r_word ? XLEN'($signed(w_mul_product[31:0]))
                               : w_mul_product;

  exe_mul_iter #(
    .XLEN              (XLEN),
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (i_ex_flush),
    .i_start  (w_hs & w_is_mul),
    .i_word   (i_ex_word),
    .i_op1    (i_ex_op1),
    .i_op2    (i_ex_op2),
    .o_done   (w_mul_done),
    .o_product(w_mul_product)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_hs) w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_mul_done) w_state_next = ST_DONE;
      ST_DONE: begin
        if (i_ex_executed_ack) begin
          if (w_hs) w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
          else      w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (i_ex_flush) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_inst    <= '0;
      r_rd_wen  <= 1'b0;
      r_rd_addr <= '0;
      r_wdata   <= '0;
      r_word    <= 1'b0;
      r_aluop   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hs) begin
        r_pc      <= i_ex_pc;
        r_inst    <= i_ex_inst;
        r_rd_wen  <= i_ex_rd_wen;
        r_rd_addr <= i_ex_rd_addr;
        r_word    <= i_ex_word;
        r_aluop   <= i_ex_aluop;
        if (!w_is_mul) r_wdata <= w_alu_result;
      end else if ((r_state == ST_BUSY) && w_mul_done && !i_ex_flush &&
                   (r_aluop == ALU_MUL)) begin
        r_wdata <= w_mul_result;
      end
    end
  end

  assign o_ex_executed_req = (r_state == ST_DONE);
  assign o_ex_busy         = (r_state == ST_BUSY);
  assign o_ex_pc           = r_pc;
  assign o_ex_inst         = r_inst;
  assign o_ex_rd_wen       = r_rd_wen;
  assign o_ex_rd_addr      = r_rd_addr;
  assign o_ex_rd_wdata     = r_wdata;

endmodule

// File: tb/tb_exe_stage_mc.sv
// ----------------------------------------------------------------------------
// tb_exe_stage_mc
// Purpose : scoreboard bench for exe_stage_mc. Two instances (XLEN=64/B=1 and
//           XLEN=32/B=4) share the op inputs; sel picks which one gets req and
//           whose outputs the monitor observes.
// ----------------------------------------------------------------------------
module tb_exe_stage_mc;
  import exe_stage_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, flush, req, ack, word, rd_wen, sel;
  logic [63:0] pc, op1, op2, pc_ctr;
  logic [31:0] inst;
  logic [3:0]  aluop;
  logic [4:0]  rd_addr;

  logic        a_dack, a_req, a_rd_wen, a_busy;
  logic [63:0] a_pc, a_wdata;
  logic [31:0] a_inst;
  logic [4:0]  a_rd_addr;
  logic        b_dack, b_req, b_rd_wen, b_busy;
  logic [31:0] b_pc, b_wdata, b_inst;
  logic [4:0]  b_rd_addr;

  exe_stage_mc #(.XLEN(64), .MUL_BITS_PER_CYCLE(1)) u_dut64 (
    .clk(clk), .rst(rst_a), .i_ex_flush(flush),
    .i_ex_decoded_req(req & ~sel), .o_ex_decoded_ack(a_dack),
    .i_ex_pc(pc), .i_ex_inst(inst), .i_ex_aluop(aluop), .i_ex_word(word),
    .i_ex_op1(op1), .i_ex_op2(op2), .i_ex_rd_wen(rd_wen), .i_ex_rd_addr(rd_addr),
    .o_ex_executed_req(a_req), .i_ex_executed_ack(ack),
    .o_ex_pc(a_pc), .o_ex_inst(a_inst), .o_ex_rd_wen(a_rd_wen),
    .o_ex_rd_addr(a_rd_addr), .o_ex_rd_wdata(a_wdata), .o_ex_busy(a_busy)
  );

  exe_stage_mc #(.XLEN(32), .MUL_BITS_PER_CYCLE(4)) u_dut32 (
    .clk(clk), .rst(rst_b), .i_ex_flush(flush),
    .i_ex_decoded_req(req & sel), .o_ex_decoded_ack(b_dack),
    .i_ex_pc(pc[31:0]), .i_ex_inst(inst), .i_ex_aluop(aluop), .i_ex_word(word),
    .i_ex_op1(op1[31:0]), .i_ex_op2(op2[31:0]), .i_ex_rd_wen(rd_wen),
    .i_ex_rd_addr(rd_addr),
    .o_ex_executed_req(b_req), .i_ex_executed_ack(ack),
    .o_ex_pc(b_pc), .o_ex_inst(b_inst), .o_ex_rd_wen(b_rd_wen),
    .o_ex_rd_addr(b_rd_addr), .o_ex_rd_wdata(b_wdata), .o_ex_busy(b_busy)
  );

  logic        m_dack, m_req, m_busy, m_rd_wen;
  logic [63:0] m_pc, m_wdata;
  logic [31:0] m_inst;
  logic [4:0]  m_rd_addr;
  assign m_dack    = sel ? b_dack : a_dack;
  assign m_req     = sel ? b_req : a_req;
  assign m_busy    = sel ? b_busy : a_busy;
  assign m_rd_wen  = sel ? b_rd_wen : a_rd_wen;
  assign m_pc      = sel ? {32'b0, b_pc} : a_pc;
  assign m_wdata   = sel ? {32'b0, b_wdata} : a_wdata;
  assign m_inst    = sel ? b_inst : a_inst;
  assign m_rd_addr = sel ? b_rd_addr : a_rd_addr;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [63:0] wdata;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Monitor: a result is consumed on every edge where req & ack (and no flush).
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a && !rst_b && m_req && ack && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got wdata=%h pc=%h required=none", m_wdata, m_pc);
      end else begin
        e = exp_q.pop_front();
        if (m_wdata !== e.wdata || m_pc !== e.pc || m_inst !== e.inst ||
            m_rd_wen !== e.rd_wen || m_rd_addr !== e.rd_addr) begin
          failures++;
          $display("FAIL result got wdata=%h pc=%h inst=%h wen=%b rd=%0d required wdata=%h pc=%h inst=%h wen=%b rd=%0d",
                   m_wdata, m_pc, m_inst, m_rd_wen, m_rd_addr,
                   e.wdata, e.pc, e.inst, e.rd_wen, e.rd_addr);
        end else begin
          $display("tb: result pc=%h rd=%0d wdata=%h ok", m_pc, m_rd_addr, m_wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send(input logic [3:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input bit push);
    int   n;
    exp_t e;
    n       = 0;
    aluop   = op;
    word    = w;
    op1     = a;
    op2     = b;
    pc      = pc_ctr;
    inst    = {16'hABCD, pc_ctr[15:0]};
    rd_addr = pc_ctr[6:2];
    rd_wen  = pc_ctr[3];
    pc_ctr  = pc_ctr + 64'd4;
    req     = 1'b1;
    @(negedge clk);
    while (!m_dack && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!m_dack) begin
      chk("send_timeout", {63'b0, m_dack}, 64'd1);
    end else if (push) begin
      e.pc = pc; e.inst = inst; e.rd_wen = rd_wen; e.rd_addr = rd_addr; e.wdata = exp;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // Called just after the handshake edge; ends on the falling edge after busy drops.
  task automatic count_busy(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (m_busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [0:11];
  int   n;
  int   bad;

  initial begin
    vecs = '{
      '{ALU_AND,  1'b0, 64'hF0F0, 64'hFF00, 64'hF000},
      '{ALU_OR,   1'b0, 64'hF0, 64'h0F, 64'hFF},
      '{ALU_XOR,  1'b0, 64'hFF, 64'h0F, 64'hF0},
      '{ALU_SLL,  1'b0, 64'h1, 64'h7F, 64'h8000_0000_0000_0000},
      '{ALU_SRL,  1'b0, 64'h8000_0000_0000_0000, 64'h4, 64'h0800_0000_0000_0000},
      '{ALU_SRA,  1'b0, 64'h8000_0000_0000_0000, 64'h4, 64'hF800_0000_0000_0000},
      '{ALU_SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1},
      '{ALU_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0},
      '{ALU_SRL,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'h4, 64'h0000_0000_0800_0000},
      '{ALU_SLL,  1'b1, 64'h1, 64'h3F, 64'hFFFF_FFFF_8000_0000},
      '{ALU_SUB,  1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF},
      '{4'hF,     1'b0, 64'h3, 64'h4, 64'h7}
    };
    rst_a = 1'b1; rst_b = 1'b1; flush = 1'b0; req = 1'b0; ack = 1'b1; sel = 1'b0;
    word = 1'b0; rd_wen = 1'b0; pc = '0; op1 = '0; op2 = '0; inst = '0;
    aluop = '0; rd_addr = '0; pc_ctr = 64'h1000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {63'b0, a_req},  64'd0);
    chk("rst_busy",  {63'b0, a_busy}, 64'd0);
    chk("rst_dack",  {63'b0, a_dack}, 64'd0);
    chk("rst_wdata", a_wdata, 64'd0);
    chk("rst_pc",    a_pc, 64'd0);
    chk("rst_b_req", {63'b0, b_req},  64'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // ADD wrap then back-to-back SUB with ack held high.
    send(ALU_ADD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    chk("add_latency_req", {63'b0, m_req}, 64'd1);
    send(ALU_SUB, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    chk("b2b_req_high", {63'b0, m_req}, 64'd1);
    send(ALU_SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b1);
    send(ALU_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
    end
    step();

    // Multiplier: 64 busy cycles, then word mode with 32.
    send(ALU_MUL, 1'b0, 64'h1234_5678, 64'h10, 64'h1_2345_6780, 1'b1);
    count_busy(n);
    chk("mul64_busy_cycles", n, 64);
    chk("mul64_req", {63'b0, m_req}, 64'd1);
    step();
    send(ALU_MUL, 1'b1, 64'h10000, 64'h10000, 64'd0, 1'b1);
    count_busy(n);
    chk("mulw_busy_cycles", n, 32);
    step();

    // Backpressure: hold result for 10 cycles, then ack together with a new op.
    ack = 1'b0;
    send(ALU_ADD, 1'b0, 64'd10, 64'd20, 64'd30, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req",   {63'b0, m_req},  64'd1);
      chk("bp_wdata", m_wdata, 64'd30);
      chk("bp_dack",  {63'b0, m_dack}, 64'd0);
    end
    step();
    ack = 1'b1;
    send(ALU_SUB, 1'b0, 64'd100, 64'd1, 64'd99, 1'b1);
    chk("bp_no_bubble", {63'b0, m_req}, 64'd1);
    step();

    // Flush during BUSY.
    send(ALU_MUL, 1'b0, 64'd3, 64'd5, 64'd0, 1'b0);
    repeat (20) @(negedge clk);
    step();
    flush = 1'b1;
    chk("flush_busy_before", {63'b0, m_busy}, 64'd1);
    step();
    flush = 1'b0;
    chk("flush_busy_after", {63'b0, m_busy}, 64'd0);
    chk("flush_req_after",  {63'b0, m_req},  64'd0);
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (m_req) bad++;
    end
    chk("flush_no_req", bad, 0);
    step();
    send(ALU_ADD, 1'b0, 64'd2, 64'd3, 64'd5, 1'b1);
    step();

    // Flush concurrent with a request: not accepted, not captured.
    aluop = ALU_ADD; word = 1'b0; op1 = 64'd9; op2 = 64'd9;
    req = 1'b1; flush = 1'b1;
    #1;
    chk("flush_dack", {63'b0, m_dack}, 64'd0);
    step();
    flush = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("flush_req_not_captured", {63'b0, m_req}, 64'd0);
    step();

    // Asynchronous reset mid-BUSY on the 64-bit instance.
    send(ALU_MUL, 1'b0, 64'd7, 64'd7, 64'd0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("arst_busy",  {63'b0, a_busy}, 64'd0);
    chk("arst_req",   {63'b0, a_req},  64'd0);
    chk("arst_wdata", a_wdata, 64'd0);
    chk("arst_pc",    a_pc, 64'd0);
    chk("arst_dack",  {63'b0, a_dack}, 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (a_req) bad++;
    end
    chk("arst_no_req", bad, 0);
    step();

    // XLEN=32, 4 multiplier bits per cycle.
    sel = 1'b1;
    send(ALU_MUL, 1'b0, 64'd7, 64'd9, 64'd63, 1'b1);
    count_busy(n);
    chk("mul32_busy_cycles", n, 8);
    step();
    send(ALU_ADD, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'd0, 1'b1);
    send(ALU_SLL, 1'b0, 64'd1, 64'h3F, 64'h0000_0000_8000_0000, 1'b1);
    send(ALU_SRA, 1'b0, 64'h8000_0000, 64'd4, 64'h0000_0000_F800_0000, 1'b1);
    step();
    send(ALU_MUL, 1'b0, 64'd3, 64'd3, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b1;
    #1;
    chk("arst32_busy",  {63'b0, b_busy}, 64'd0);
    chk("arst32_req",   {63'b0, b_req},  64'd0);
    chk("arst32_wdata", {32'b0, b_wdata}, 64'd0);
    @(negedge clk);
    rst_b = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (b_req) bad++;
    end
    chk("arst32_no_req", bad, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
- Next-generation execute stage: parametrised XLEN, full req/ack backpressure, pipeline flush, and a multi-cycle iterative multiplier alongside the 1-cycle integer ALU.
- Sits between decode and memory stages; holds its result until the memory stage acknowledges.
- Supports RV64 word-mode (*W) operations with sign-extended 32-bit results.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle (1, 2, 4 or 8; must divide 32).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_ex_flush  in  1  kill in-flight op (branch redirect/trap).
- i_ex_decoded_req  in  1  decode has a valid op.
- o_ex_decoded_ack  out  1  stage accepts op this cycle.
- i_ex_pc  in  XLEN  instruction PC.
- i_ex_inst  in  32  instruction word.
- i_ex_aluop  in  4  op code (package enum).
- i_ex_word  in  1  32-bit word-mode op.
- i_ex_op1  in  XLEN  operand 1.
- i_ex_op2  in  XLEN  operand 2.
- i_ex_rd_wen  in  1  writes rd.
- i_ex_rd_addr  in  5  rd index.
- o_ex_executed_req  out  1  result valid.
- i_ex_executed_ack  in  1  downstream consumes result.
- o_ex_pc  out  XLEN  held PC.
- o_ex_inst  out  32  held instruction.
- o_ex_rd_wen  out  1  held rd write enable.
- o_ex_rd_addr  out  5  held rd index.
- o_ex_rd_wdata  out  XLEN  result.
- o_ex_busy  out  1  multiplier iterating.

Behaviour:
- Reset: all outputs 0; state IDLE; every holding register 0.
- FSM states and moves:
  - IDLE: handshake with a 1-cycle op -> DONE; with MUL -> BUSY.
  - BUSY: counter reaches the last step -> DONE.
  - DONE: ack without a new handshake -> IDLE; ack with a new handshake -> DONE or BUSY (back-to-back).
- o_ex_decoded_ack = ~i_ex_flush & (IDLE | (DONE & i_ex_executed_ack)); combinational. Handshake = req & ack.
- On handshake: pc, inst, rd_wen, rd_addr, word and aluop are latched.
  - 1-cycle op: result registered into o_ex_rd_wdata at the same edge; o_ex_executed_req=1 next cycle (latency 1).
  - MUL: operands latched into multiplicand/multiplier/accumulator; o_ex_busy=1.
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU (1 cycle); MUL (low XLEN bits of product).
- Arithmetic/width rules:
  - Shift amount = op2[log2(XLEN)-1:0], or op2[4:0] in word mode.
  - Word mode: operate on op1[31:0]/op2[31:0]. SRA in word mode shifts the sign-extended low word. Result[31:0] is sign-extended to XLEN.
  - SLT/SLTU result is 0 or 1, zero-extended.
  - Overflow wraps modulo 2^XLEN.
- MUL timing:
  - Each BUSY cycle retires MUL_BITS_PER_CYCLE multiplier bits (shift-add).
  - BUSY lasts XLEN/MUL_BITS_PER_CYCLE cycles, or 32/MUL_BITS_PER_CYCLE in word mode. Total handshake-to-req latency = that count + 1.
  - Signedness is irrelevant for low bits.
- DONE: all o_ex_* outputs stay stable while o_ex_executed_req=1 and ack=0.
  - Ack deasserts req at the next edge unless a new 1-cycle op is accepted in the same cycle; then req stays 1 with new data.
- Flush has priority over everything:
  - State -> IDLE; o_ex_executed_req=0 and o_ex_busy=0 at the next edge.
  - No handshake in the flush cycle.
  - A flush in BUSY discards the partial product.
  - A flush coinciding with ack is treated as flush.
- Async reset mid-BUSY: immediate return to reset values; no result is ever issued.
- Unknown aluop: treated as ADD.
- o_ex_rd_wen is passed through unchanged; the stage never suppresses it except via flush/reset clearing req.

Decomposition:
- Shared package (defines): aluop enum constants (ALU_ADD..ALU_MUL), FSM state encodings, XLEN default.
- One sub-module: exe_mul_iter — iterative multiplier with start/word inputs and done/product outputs, parametrised by XLEN and MUL_BITS_PER_CYCLE.
- The combinational ALU stays inline.

Test Plan:
- ADD, op1=0xFFFF_FFFF_FFFF_FFFF, op2=1, ack held 1 -> o_ex_executed_req high 1 cycle after handshake, wdata=0. Back-to-back SUB 5-7 -> wdata=0xFFFF_FFFF_FFFF_FFFE, req continuously high.
- Word-mode SRA: op1=0x0000_0000_8000_0000, op2=4 -> wdata=0xFFFF_FFFF_F800_0000. Word ADD 0x7FFF_FFFF+1 -> 0xFFFF_FFFF_8000_0000.
- MUL with MUL_BITS_PER_CYCLE=1: 0x1234_5678 × 0x10 -> o_ex_busy high 64 cycles, req at cycle 65, wdata=0x1_2345_6780. Word MUL 0x10000 × 0x10000 -> 32 busy cycles, wdata=0.
- Backpressure: result held with ack=0 for 10 cycles -> outputs stable, o_ex_decoded_ack=0 throughout. Ack plus new req in the same cycle -> accepted with no bubble.
- Flush at BUSY cycle 20 -> req never rises, busy drops next edge, next op ADD 2+3 -> wdata=5. Flush concurrent with req -> decoded_ack=0, op not captured.
- Async rst asserted mid-BUSY between edges -> all outputs 0 immediately. Repeat with MUL_BITS_PER_CYCLE=4 and XLEN=32; MUL 7×9 -> 63 after 8 busy cycles.
